// File: rtl/seq_subtractor.sv
// Multi-cycle subtractor: WIDTH-bit operands processed CHUNK bits per clock, LSB chunk first.
// Optional build macro SEQ_SUBTRACTOR_SAT_EN clamps a negative difference to zero.
module seq_subtractor #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_sub1,
  input  logic [WIDTH-1:0] i_sub2,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [1:0]       o_state
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic [WIDTH-1:0] diff_next, final_diff;
  logic [WIDTH:0]   result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             borrow_q;
  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic [CHUNK:0]   chunk_diff;
  logic             last_chunk;
  int               idx;

  // Handshake: operands are taken on an edge where i_valid && o_ready (IDLE only);
  // a result is consumed on an edge where o_valid && i_ready (DONE only). Nothing is queued.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = CALC;
      end
      CALC: begin
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One chunk per cycle; bit CHUNK of the (CHUNK+1)-bit difference is the outgoing borrow.
  always_comb begin
    idx        = int'(cnt_q) * CHUNK;
    chunk_a    = a_q[idx +: CHUNK];
    chunk_b    = b_q[idx +: CHUNK];
    chunk_diff = {1'b0, chunk_a} - {1'b0, chunk_b} - {{CHUNK{1'b0}}, borrow_q};
    diff_next  = diff_q;
    diff_next[idx +: CHUNK] = chunk_diff[CHUNK-1:0];
    last_chunk = (cnt_q == CNT_W'(N - 1));
  end

`ifdef SEQ_SUBTRACTOR_SAT_EN
  assign final_diff = chunk_diff[CHUNK] ? '0 : diff_next;
`else
  assign final_diff = diff_next;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            a_q      <= i_sub1;
            b_q      <= i_sub2;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
          end
        end
        CALC: begin
          diff_q   <= diff_next;
          borrow_q <= chunk_diff[CHUNK];
          cnt_q    <= cnt_q + 1'b1;
          if (last_chunk) result_q <= {chunk_diff[CHUNK], final_diff};
        end
        default: ;
      endcase
    end
  end

  assign o_result = result_q;
  assign o_state  = state_q;

endmodule

// File: tb/tb_seq_subtractor.sv
// Directed bench for seq_subtractor (WIDTH=16, CHUNK=4); one task per scenario.
// Borrow expectations follow SEQ_SUBTRACTOR_SAT_EN when it is defined for the build.
module tb_seq_subtractor;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] i_sub1, i_sub2;
  logic        i_valid;
  logic        o_ready;
  logic [16:0] o_result;
  logic        o_valid;
  logic        i_ready;
  logic [1:0]  o_state;

  int checks = 0;
  int errors = 0;

  seq_subtractor #(.WIDTH(16), .CHUNK(4)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_sub1   (i_sub1),
    .i_sub2   (i_sub2),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_result (o_result),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_state  (o_state)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Called at a negedge with the DUT idle; returns at the negedge after the accept edge,
  // with the operand inputs scrambled so late changes would be noticed.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    i_sub1  = a;
    i_sub2  = b;
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    i_sub1  = ~a;
    i_sub2  = ~b;
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_valid = 1'b1; i_ready = 1'b0;
    i_sub1 = 16'h1111; i_sub2 = 16'h2222;
    repeat (3) @(negedge i_clk);
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", o_state); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_result !== 17'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000", o_result); end
    i_rst = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    @(negedge i_clk);
    checks++; if (o_ready !== 1'b1 || o_state !== 2'd0) begin errors++; $display("FAIL reset_release_ready: ready %b state %0d expected 1/0", o_ready, o_state); end
  endtask

  task automatic test_basic;
    int c;
    int busy_bad;
    i_ready = 1'b1;
    start_op(16'h1234, 16'h0034);
    c = 1; busy_bad = 0;
    while (o_valid !== 1'b1 && c < 20) begin
      if (o_ready !== 1'b0) busy_bad++;
      @(negedge i_clk); c++;
    end
    checks++; if (c !== 5) begin errors++; $display("FAIL basic_latency: got %0d cycles expected 5", c); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL basic_busy_ready: %0d busy cycles with o_ready high, expected 0", busy_bad); end
    checks++; if (o_result !== 17'h01200) begin errors++; $display("FAIL basic_result: got %h expected 01200", o_result); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL basic_done_ready: got %b expected 0", o_ready); end
    @(negedge i_clk);
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL basic_valid_pulse: valid %b ready %b expected 0/1", o_valid, o_ready); end
    checks++; if (o_result !== 17'h01200) begin errors++; $display("FAIL basic_hold_idle: got %h expected 01200", o_result); end
  endtask

  task automatic test_borrow;
    int c;
    logic [16:0] exp;
`ifdef SEQ_SUBTRACTOR_SAT_EN
    exp = 17'h10000;
`else
    exp = 17'h1FFFF;
`endif
    i_ready = 1'b1;
    start_op(16'h0000, 16'h0001);
    c = 1;
    while (o_valid !== 1'b1 && c < 20) begin @(negedge i_clk); c++; end
    checks++; if (c !== 5) begin errors++; $display("FAIL borrow_latency: got %0d cycles expected 5", c); end
    checks++; if (o_result !== exp) begin errors++; $display("FAIL borrow_result: got %h expected %h", o_result, exp); end
    @(negedge i_clk);
  endtask

  task automatic test_backpressure;
    int c;
    i_ready = 1'b0;
    start_op(16'hFFFF, 16'h8001);
    c = 1;
    while (o_valid !== 1'b1 && c < 20) begin @(negedge i_clk); c++; end
    checks++; if (c !== 5) begin errors++; $display("FAIL bp_latency: got %0d cycles expected 5", c); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== 17'h07FFE) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid %b ready %b result %h expected 1/0/07FFE", i, o_valid, o_ready, o_result);
      end
      @(negedge i_clk);
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    checks++; if (o_state !== 2'd0 || o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL bp_release: state %0d valid %b ready %b expected 0/0/1", o_state, o_valid, o_ready); end
  endtask

  task automatic test_busy_ignore;
    int c;
    int stray;
    i_ready = 1'b1;
    start_op(16'h00F0, 16'h000F);
    i_sub1 = 16'h0005; i_sub2 = 16'h0003; i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    c = 2;
    while (o_valid !== 1'b1 && c < 20) begin @(negedge i_clk); c++; end
    checks++; if (c !== 5) begin errors++; $display("FAIL busy_latency: got %0d cycles expected 5", c); end
    checks++; if (o_result !== 17'h000E1) begin errors++; $display("FAIL busy_result: got %h expected 000E1", o_result); end
    stray = 0;
    repeat (10) begin @(negedge i_clk); if (o_valid !== 1'b0) stray++; end
    checks++; if (stray !== 0) begin errors++; $display("FAIL busy_no_second: %0d stray valid cycles expected 0", stray); end
  endtask

  task automatic test_midop_reset;
    int c;
    int stray;
    i_ready = 1'b1;
    start_op(16'hABCD, 16'h1111);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    checks++; if (o_result !== 17'h0) begin errors++; $display("FAIL midrst_result: got %h expected 00000", o_result); end
    checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL midrst_ready: ready %b valid %b expected 1/0", o_ready, o_valid); end
    stray = 0;
    repeat (10) begin @(negedge i_clk); if (o_valid !== 1'b0) stray++; end
    checks++; if (stray !== 0) begin errors++; $display("FAIL midrst_no_valid: %0d valid cycles expected 0", stray); end
    start_op(16'h0010, 16'h0010);
    c = 1;
    while (o_valid !== 1'b1 && c < 20) begin @(negedge i_clk); c++; end
    checks++; if (c !== 5) begin errors++; $display("FAIL midrst_next_latency: got %0d cycles expected 5", c); end
    checks++; if (o_result !== 17'h0) begin errors++; $display("FAIL midrst_next_result: got %h expected 00000", o_result); end
    @(negedge i_clk);
  endtask

  task automatic test_back_to_back;
    int c;
    logic [16:0] exp2;
`ifdef SEQ_SUBTRACTOR_SAT_EN
    exp2 = 17'h10000;
`else
    exp2 = 17'h10002;
`endif
    i_ready = 1'b1;
    start_op(16'h8000, 16'h7FFF);
    c = 1;
    while (o_valid !== 1'b1 && c < 20) begin @(negedge i_clk); c++; end
    checks++; if (o_result !== 17'h00001) begin errors++; $display("FAIL b2b_first: got %h expected 00001", o_result); end
    @(negedge i_clk);
    start_op(16'h0001, 16'hFFFF);
    c = 1;
    while (o_valid !== 1'b1 && c < 20) begin @(negedge i_clk); c++; end
    checks++; if (c !== 5) begin errors++; $display("FAIL b2b_latency: got %0d cycles expected 5", c); end
    checks++; if (o_result !== exp2) begin errors++; $display("FAIL b2b_second: got %h expected %h", o_result, exp2); end
    @(negedge i_clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_backpressure();
    test_busy_ignore();
    test_midop_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
